pipeline_ctrl: RTL and testbench



---
 rtl/pipeline_ctrl_pkg.sv | 20 ++
 rtl/pipeline_ctrl_if.sv | 58 +++++
 rtl/pipeline_ctrl_hazard_detect.sv | 35 +++
 rtl/pipeline_ctrl.sv | 140 ++++++++++++++
 tb/tb_pipeline_ctrl.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/pipeline_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_ctrl_pkg
//  Description : Shared types and constants for the pipeline sequencing
//                controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package pipeline_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RUN    = 2'd1,
      ST_HALTED = 2'd2
   } state_e;

   localparam logic [6:0] c_ECALL_OPCODE = 7'h73;
   localparam logic [4:0] c_X0_IDX       = 5'd0;

endpackage : pipeline_ctrl_pkg
`default_nettype wire

// File: rtl/pipeline_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_ctrl_if
//  Description : Bundle between the datapath and the pipeline controller.
//  Revision    : 1.0 - initial release
// ============================================================================
interface pipeline_ctrl_if #(
   parameter int CNT_W = 32
);
   logic             enable;
   logic [4:0]       rs1_id;
   logic [4:0]       rs2_id;
   logic             use_rs1_id;
   logic             use_rs2_id;
   logic [4:0]       rd_ex;
   logic             mem_read_ex;
   logic             branch_mem;
   logic             zero_flag_mem;
   logic             jump_mem;
   logic             retire_wb;
   logic             halt_wb;

   logic             pc_en;
   logic             if_id_en;
   logic             id_ex_en;
   logic             ex_mem_en;
   logic             mem_wb_en;
   logic             if_id_flush;
   logic             id_ex_flush;
   logic             ex_mem_flush;
   logic             running;
   logic             halted;
   logic [CNT_W-1:0] cycle_cnt;
   logic [CNT_W-1:0] retire_cnt;
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] flush_cnt;

   // Datapath side: supplies pipeline status, consumes controls.
   modport master (
      output enable, rs1_id, rs2_id, use_rs1_id, use_rs2_id, rd_ex,
             mem_read_ex, branch_mem, zero_flag_mem, jump_mem,
             retire_wb, halt_wb,
      input  pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
             if_id_flush, id_ex_flush, ex_mem_flush, running, halted,
             cycle_cnt, retire_cnt, stall_cnt, flush_cnt
   );

   modport slave (
      input  enable, rs1_id, rs2_id, use_rs1_id, use_rs2_id, rd_ex,
             mem_read_ex, branch_mem, zero_flag_mem, jump_mem,
             retire_wb, halt_wb,
      output pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
             if_id_flush, id_ex_flush, ex_mem_flush, running, halted,
             cycle_cnt, retire_cnt, stall_cnt, flush_cnt
   );

endinterface : pipeline_ctrl_if
`default_nettype wire

// File: rtl/pipeline_ctrl_hazard_detect.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_detect
//  Description : Combinational load-use hazard and MEM-stage redirect decode.
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_detect
   import pipeline_ctrl_pkg::*;
(
   input  wire logic [4:0] rs1_id_i,
   input  wire logic [4:0] rs2_id_i,
   input  wire logic       use_rs1_id_i,
   input  wire logic       use_rs2_id_i,
   input  wire logic [4:0] rd_ex_i,
   input  wire logic       mem_read_ex_i,
   input  wire logic       branch_mem_i,
   input  wire logic       zero_flag_mem_i,
   input  wire logic       jump_mem_i,
   output logic            hazard_o,
   output logic            redirect_o
);

   logic w_rs1_match;
   logic w_rs2_match;

   assign w_rs1_match = use_rs1_id_i && (rs1_id_i == rd_ex_i);
   assign w_rs2_match = use_rs2_id_i && (rs2_id_i == rd_ex_i);

   // x0 is hardwired to zero, so a load targeting it never creates a dependency.
   assign hazard_o   = mem_read_ex_i && (rd_ex_i != c_X0_IDX) &&
                       (w_rs1_match || w_rs2_match);
   assign redirect_o = jump_mem_i || (branch_mem_i && zero_flag_mem_i);

endmodule : hazard_detect
`default_nettype wire

// File: rtl/pipeline_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_ctrl
//  Description : Run/halt sequencer, stall/flush control and performance
//                counters for the 5-stage pipeline.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipeline_ctrl
   import pipeline_ctrl_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  wire logic        clk,
   input  wire logic        arst_n,
   pipeline_ctrl_if.slave   bus_io
);

   state_e           state_q, state_d;
   logic             running_q, halted_q;
   logic [CNT_W-1:0] cycle_cnt_q,  cycle_cnt_d;
   logic [CNT_W-1:0] retire_cnt_q, retire_cnt_d;
   logic [CNT_W-1:0] stall_cnt_q,  stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q,  flush_cnt_d;
   logic             w_hazard;
   logic             w_redirect;
   logic             w_stall;
   logic             w_in_run;

   hazard_detect u_hazard_detect (
      .rs1_id_i        (bus_io.rs1_id),
      .rs2_id_i        (bus_io.rs2_id),
      .use_rs1_id_i    (bus_io.use_rs1_id),
      .use_rs2_id_i    (bus_io.use_rs2_id),
      .rd_ex_i         (bus_io.rd_ex),
      .mem_read_ex_i   (bus_io.mem_read_ex),
      .branch_mem_i    (bus_io.branch_mem),
      .zero_flag_mem_i (bus_io.zero_flag_mem),
      .jump_mem_i      (bus_io.jump_mem),
      .hazard_o        (w_hazard),
      .redirect_o      (w_redirect)
   );

   assign w_in_run = (state_q == ST_RUN);
   assign w_stall  = w_hazard && !w_redirect;

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         state_q   <= ST_IDLE;
         running_q <= 1'b0;
         halted_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         running_q <= (state_d == ST_RUN);
         halted_q  <= (state_d == ST_HALTED);
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:   if (bus_io.enable)  state_d = ST_RUN;
         ST_RUN: begin
            if (bus_io.halt_wb)         state_d = ST_HALTED;
            else if (!bus_io.enable)    state_d = ST_IDLE;
         end
         ST_HALTED: if (!bus_io.enable) state_d = ST_IDLE;
         default:                       state_d = ST_IDLE;
      endcase
   end

   // Redirect squashes the three younger stages and wins over a stall.
   always_comb begin
      bus_io.pc_en        = 1'b0;
      bus_io.if_id_en     = 1'b0;
      bus_io.id_ex_en     = 1'b0;
      bus_io.ex_mem_en    = 1'b0;
      bus_io.mem_wb_en    = 1'b0;
      bus_io.if_id_flush  = 1'b0;
      bus_io.id_ex_flush  = 1'b0;
      bus_io.ex_mem_flush = 1'b0;
      if (w_in_run) begin
         bus_io.id_ex_en  = 1'b1;
         bus_io.ex_mem_en = 1'b1;
         bus_io.mem_wb_en = 1'b1;
         if (w_redirect) begin
            bus_io.pc_en        = 1'b1;
            bus_io.if_id_en     = 1'b1;
            bus_io.if_id_flush  = 1'b1;
            bus_io.id_ex_flush  = 1'b1;
            bus_io.ex_mem_flush = 1'b1;
         end else if (w_hazard) begin
            bus_io.id_ex_flush  = 1'b1;
         end else begin
            bus_io.pc_en        = 1'b1;
            bus_io.if_id_en     = 1'b1;
         end
      end
   end

   always_comb begin
      cycle_cnt_d  = cycle_cnt_q;
      retire_cnt_d = retire_cnt_q;
      stall_cnt_d  = stall_cnt_q;
      flush_cnt_d  = flush_cnt_q;
      if (state_q == ST_IDLE && bus_io.enable) begin
         cycle_cnt_d  = '0;
         retire_cnt_d = '0;
         stall_cnt_d  = '0;
         flush_cnt_d  = '0;
      end else if (w_in_run) begin
         cycle_cnt_d  = cycle_cnt_q  + CNT_W'(1);
         retire_cnt_d = retire_cnt_q + CNT_W'(bus_io.retire_wb);
         stall_cnt_d  = stall_cnt_q  + CNT_W'(w_stall);
         flush_cnt_d  = flush_cnt_q  + CNT_W'(w_redirect);
      end
   end

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         cycle_cnt_q  <= '0;
         retire_cnt_q <= '0;
         stall_cnt_q  <= '0;
         flush_cnt_q  <= '0;
      end else begin
         cycle_cnt_q  <= cycle_cnt_d;
         retire_cnt_q <= retire_cnt_d;
         stall_cnt_q  <= stall_cnt_d;
         flush_cnt_q  <= flush_cnt_d;
      end
   end

   assign bus_io.running    = running_q;
   assign bus_io.halted     = halted_q;
   assign bus_io.cycle_cnt  = cycle_cnt_q;
   assign bus_io.retire_cnt = retire_cnt_q;
   assign bus_io.stall_cnt  = stall_cnt_q;
   assign bus_io.flush_cnt  = flush_cnt_q;

endmodule : pipeline_ctrl
`default_nettype wire

// File: tb/tb_pipeline_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipeline_ctrl
//  Description : Directed self-checking bench for pipeline_ctrl.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_ctrl;
   import pipeline_ctrl_pkg::*;

   localparam int CNT_W = 32;

   logic clk;
   logic arst_n;
   int   n_tests;
   int   n_fail;

   pipeline_ctrl_if #(.CNT_W(CNT_W)) bus ();

   pipeline_ctrl #(.CNT_W(CNT_W)) dut (
      .clk    (clk),
      .arst_n (arst_n),
      .bus_io (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      bus.rs1_id        = 5'd0;
      bus.rs2_id        = 5'd0;
      bus.use_rs1_id    = 1'b0;
      bus.use_rs2_id    = 1'b0;
      bus.rd_ex         = 5'd0;
      bus.mem_read_ex   = 1'b0;
      bus.branch_mem    = 1'b0;
      bus.zero_flag_mem = 1'b0;
      bus.jump_mem      = 1'b0;
      bus.retire_wb     = 1'b0;
      bus.halt_wb       = 1'b0;
   endtask

   // Packs {pc,if_id,id_ex,ex_mem,mem_wb} enables and {if_id,id_ex,ex_mem} flushes.
   function automatic logic [7:0] ctl();
      return {bus.pc_en, bus.if_id_en, bus.id_ex_en, bus.ex_mem_en, bus.mem_wb_en,
              bus.if_id_flush, bus.id_ex_flush, bus.ex_mem_flush};
   endfunction

   initial begin
      logic [9:0] retire_pat;
      n_tests = 0;
      n_fail  = 0;
      retire_pat = 10'b1011011011;

      arst_n     = 1'b0;
      bus.enable = 1'b0;
      clear_inputs();
      repeat (2) tick();
      #2 arst_n = 1'b1;

      repeat (5) tick();
      chk("idle_ctl",      ctl(),          8'b00000_000);
      chk("idle_running",  bus.running,    1'b0);
      chk("idle_halted",   bus.halted,     1'b0);
      chk("idle_cycle",    bus.cycle_cnt,  0);
      chk("idle_stall",    bus.stall_cnt,  0);

      bus.enable = 1'b1;
      tick();
      chk("run_running",   bus.running,    1'b1);
      chk("run_ctl",       ctl(),          8'b11111_000);

      bus.mem_read_ex = 1'b1; bus.rd_ex = 5'd5; bus.rs1_id = 5'd5; bus.use_rs1_id = 1'b1;
      #1;
      chk("hz_ctl",        ctl(),          8'b00111_010);
      tick();
      chk("hz_stall",      bus.stall_cnt,  1);
      chk("hz_cycle",      bus.cycle_cnt,  1);

      bus.rd_ex = 5'd0;
      #1;
      chk("x0_ctl",        ctl(),          8'b11111_000);
      tick();
      chk("x0_stall",      bus.stall_cnt,  1);

      bus.rd_ex = 5'd7; bus.rs1_id = 5'd3; bus.rs2_id = 5'd7; bus.use_rs2_id = 1'b0;
      #1;
      chk("rs2_unused",    ctl(),          8'b11111_000);
      bus.use_rs2_id = 1'b1;
      #1;
      chk("rs2_hz_ctl",    ctl(),          8'b00111_010);
      tick();
      chk("rs2_stall",     bus.stall_cnt,  2);

      bus.branch_mem = 1'b1; bus.zero_flag_mem = 1'b1;
      #1;
      chk("br_hz_ctl",     ctl(),          8'b11111_111);
      tick();
      chk("br_flush",      bus.flush_cnt,  1);
      chk("br_stall",      bus.stall_cnt,  2);

      clear_inputs();
      bus.branch_mem = 1'b1; bus.zero_flag_mem = 1'b0;
      #1;
      chk("br_nt_ctl",     ctl(),          8'b11111_000);
      tick();
      chk("br_nt_flush",   bus.flush_cnt,  1);

      clear_inputs();
      bus.jump_mem = 1'b1;
      #1;
      chk("jmp_ctl",       ctl(),          8'b11111_111);
      tick();
      chk("jmp_flush",     bus.flush_cnt,  2);
      clear_inputs();

      bus.enable = 1'b0;
      tick();
      chk("stop_running",  bus.running,    1'b0);
      chk("stop_ctl",      ctl(),          8'b00000_000);
      chk("stop_cycle",    bus.cycle_cnt,  7);
      tick();
      chk("idle_hold",     bus.cycle_cnt,  7);

      bus.enable = 1'b1;
      tick();
      chk("rerun_cycle",   bus.cycle_cnt,  0);
      chk("rerun_flush",   bus.flush_cnt,  0);
      for (int i = 0; i < 10; i++) begin
         bus.retire_wb = retire_pat[i];
         tick();
      end
      bus.retire_wb = 1'b0;
      bus.halt_wb   = 1'b1;
      #1;
      chk("halt_cyc_ctl",  ctl(),          8'b11111_000);
      tick();
      bus.halt_wb = 1'b0;
      chk("halted",        bus.halted,     1'b1);
      chk("halt_running",  bus.running,    1'b0);
      chk("halt_ctl",      ctl(),          8'b00000_000);
      chk("halt_cycle",    bus.cycle_cnt,  11);
      chk("halt_retire",   bus.retire_cnt, 7);
      bus.retire_wb = 1'b1;
      tick();
      chk("halt_sticky",   bus.halted,     1'b1);
      chk("halt_retire2",  bus.retire_cnt, 7);
      bus.retire_wb = 1'b0;

      bus.enable = 1'b0;
      tick();
      chk("unhalt",        bus.halted,     1'b0);
      chk("unhalt_cycle",  bus.cycle_cnt,  11);

      bus.enable = 1'b1;
      repeat (4) tick();
      chk("pre_rst_cycle", bus.cycle_cnt,  3);
      #2 arst_n = 1'b0;
      #1;
      chk("arst_running",  bus.running,    1'b0);
      chk("arst_ctl",      ctl(),          8'b00000_000);
      chk("arst_cycle",    bus.cycle_cnt,  0);
      tick();
      arst_n = 1'b1;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_pipeline_ctrl
`default_nettype wire
